// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared word width, NOP encoding, fetch FSM states and IF/ID bundle
package pipeline_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} fetch_state_t;
  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc_plus_two;
    logic              valid;
  } if_id_t;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with hold (stall) and flush (redirect) controls
module if_id_register import pipeline_pkg::*; #(
  parameter logic [WORD_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clock)
    if (reset) q <= if_id_t'{instruction: NOP_INSTR, pc_plus_two: '0, valid: 1'b0};
    else if (!hold) q <= (d.valid && !flush) ? d : if_id_t'{instruction: NOP_INSTR, pc_plus_two: q.pc_plus_two, valid: 1'b0};
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, valid/ack imem port and IF/ID register with stall/redirect handling; FETCH_STATS_EN adds fetch_count/stall_count
module fetch_stage import pipeline_pkg::*; #(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_F,
  input  logic              pc_src,
  input  logic [WORD_W-1:0] jump_address,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc_plus_two,
  output logic              valid_D
`ifdef FETCH_STATS_EN
  ,
  output logic [WORD_W-1:0] fetch_count,
  output logic [WORD_W-1:0] stall_count
`endif
);
  fetch_state_t state, state_nxt;
  logic [WORD_W-1:0] pc, pc_nxt, redirect_pc, redirect_nxt, skid, skid_nxt, pc_inc, target;
  logic redirect;
  if_id_t d, q;
  assign redirect = pc_src && !stall_F;
  assign pc_inc = pc + 16'd2;
  assign target = {jump_address[WORD_W-1:1], 1'b0};
  assign imem_req = !reset && state != HOLD;
  assign imem_addr = pc;
  assign instruction = q.instruction;
  assign pc_plus_two = q.pc_plus_two;
  assign valid_D = q.valid;
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    redirect_nxt = redirect_pc;
    skid_nxt = skid;
    d = if_id_t'{instruction: imem_rdata, pc_plus_two: pc_inc, valid: 1'b0};
    case (state)
      FETCH: begin
        d.valid = imem_ack;
        if (imem_ack && stall_F) begin
          skid_nxt = imem_rdata;
          state_nxt = HOLD;
        end else if (redirect) begin
          pc_nxt = imem_ack ? target : pc;
          redirect_nxt = target;
          state_nxt = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) pc_nxt = pc_inc;
      end
      HOLD: begin
        d.instruction = skid;
        d.valid = 1'b1;
        if (!stall_F) begin
          pc_nxt = redirect ? target : pc_inc;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        redirect_nxt = redirect ? target : redirect_pc;
        if (imem_ack) begin
          pc_nxt = redirect ? target : redirect_pc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      redirect_pc <= RESET_PC;
      skid <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      redirect_pc <= redirect_nxt;
      skid <= skid_nxt;
    end
  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clock(clock),
    .reset(reset),
    .hold(stall_F),
    .flush(redirect),
    .d(d),
    .q(q)
  );
`ifdef FETCH_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (d.valid && !stall_F && !redirect && fetch_count != '1) fetch_count <= fetch_count + 16'd1;
      if (stall_F && stall_count != '1) stall_count <= stall_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic checked against a transaction-level fetch model
module tb_fetch_stage;
  localparam logic [15:0] NOP = 16'h0000;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stall_F = 1'b0;
  logic pc_src = 1'b0;
  logic [15:0] jump_address = '0;
  logic imem_req;
  logic [15:0] imem_addr;
  logic imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instruction, pc_plus_two;
  logic valid_D;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count, stall_count;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  fetch_stage dut (
    .clock(clock),
    .reset(reset),
    .stall_F(stall_F),
    .pc_src(pc_src),
    .jump_address(jump_address),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .pc_plus_two(pc_plus_two),
    .valid_D(valid_D)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [15:0] m_pc, m_instr, m_ppt, m_target;
  logic m_valid, m_stale;
  logic [15:0] m_skid[$];
  int m_fetches, m_stalls;
  task automatic model_reset();
    m_pc = 16'h0000;
    m_instr = NOP;
    m_ppt = 16'h0000;
    m_valid = 1'b0;
    m_stale = 1'b0;
    m_target = 16'h0000;
    m_skid.delete();
    m_fetches = 0;
    m_stalls = 0;
  endtask
  task automatic deliver(input logic [15:0] word);
    m_instr = word;
    m_ppt = m_pc + 16'd2;
    m_valid = 1'b1;
    m_pc = m_pc + 16'd2;
    if (m_fetches < 65535) m_fetches++;
  endtask
  task automatic bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask
  initial begin
    int lat_min, lat_max, stall_pct, redir_pct, mem_wait;
    logic mem_busy, exp_req, redir;
    logic [15:0] tgt;
    mem_busy = 1'b0;
    mem_wait = 0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock);
      #1;
      check("instruction", instruction, m_instr);
      check("pc_plus_two", pc_plus_two, m_ppt);
      check("valid_D", {15'd0, valid_D}, {15'd0, m_valid});
`ifdef FETCH_STATS_EN
      check("fetch_count", fetch_count, 16'(m_fetches));
      check("stall_count", stall_count, 16'(m_stalls));
`endif
      lat_min = (cyc >= 40 && cyc < 60) ? 1 : 0;
      lat_max = cyc < 40 ? 0 : cyc < 60 ? 1 : 2;
      stall_pct = cyc < 60 ? 0 : 20;
      redir_pct = cyc < 60 ? 0 : 8;
      reset = cyc < 2 || (cyc > 100 && $urandom_range(0, 299) == 0);
      stall_F = $urandom_range(0, 99) < stall_pct;
      pc_src = $urandom_range(0, 99) < redir_pct;
      jump_address = 16'($urandom);
      if (cyc == 20) begin
        pc_src = 1'b1;
        jump_address = 16'hFFFB;
      end
      #1;
      exp_req = !reset && m_skid.size() == 0;
      check("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      if (!exp_req) begin
        mem_busy = 1'b0;
        imem_ack = 1'b0;
      end else begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = $urandom_range(lat_min, lat_max);
        end
        imem_ack = mem_wait == 0;
        if (imem_ack) mem_busy = 1'b0;
        else mem_wait--;
      end
      imem_rdata = imem_ack ? (m_pc ^ 16'h5A5A) : 16'($urandom);
      redir = pc_src && !stall_F;
      tgt = jump_address & 16'hFFFE;
      if (reset) model_reset();
      else begin
        if (stall_F && m_stalls < 65535) m_stalls++;
        if (m_skid.size() != 0) begin
          if (!stall_F) begin
            if (redir) begin
              bubble();
              m_pc = tgt;
            end else deliver(m_skid[0]);
            m_skid.delete();
          end
        end else if (m_stale) begin
          if (!stall_F) bubble();
          if (redir) m_target = tgt;
          if (imem_ack) begin
            m_stale = 1'b0;
            m_pc = m_target;
          end
        end else if (stall_F) begin
          if (imem_ack) m_skid.push_back(imem_rdata);
        end else if (redir) begin
          bubble();
          if (imem_ack) m_pc = tgt;
          else begin
            m_stale = 1'b1;
            m_target = tgt;
          end
        end else if (imem_ack) deliver(imem_rdata);
        else bubble();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
